// File: rtl/dug_row_reader_if.sv
// Row-fetch handshake between the dug-row reader (master) and the dug map (slave).
interface dug_row_reader_if;
  logic        row_req;
  logic [4:0]  row_addr;
  logic        row_ack;
  logic [31:0] row_data;

  modport master (
    output row_req,
    output row_addr,
    input  row_ack,
    input  row_data
  );

  modport slave (
    input  row_req,
    input  row_addr,
    output row_ack,
    output row_data
  );
endinterface

// File: rtl/dug_row_reader.sv
// Fetches one dug-map row per tile row during hblank and streams a per-pixel is_dug flag
// aligned to the VGA scan with one cycle of latency.
module dug_row_reader #(
  parameter int unsigned PLAY_Y0  = 96,
  parameter int unsigned COLS     = 32,
  parameter int unsigned ROWS     = 24,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     pix_en,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  dug_row_reader_if.master         map,
  output logic                     is_dug,
  output logic                     is_dug_valid,
  output logic                     fetch_err
);

  localparam logic [9:0] PlayY0  = 10'(PLAY_Y0);
  localparam logic [9:0] PlayEnd = 10'(PLAY_Y0 + 16 * ROWS);
  localparam logic [9:0] XEnd    = 10'(16 * COLS);
  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] YLast   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] active_q, active_d;
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_valid_q, shadow_valid_d;
  logic [4:0]  row_addr_q, row_addr_d;
  logic        fetch_err_q, fetch_err_d;
  logic        is_dug_q, is_dug_d;
  logic        is_dug_valid_q, is_dug_valid_d;

  logic [9:0] y_next;
  logic [9:0] yn_rel;
  logic [3:0] y_phase;
  logic [4:0] col;
  logic       yn_in_field, y_in_field, trigger, line_start;

  assign y_next      = (DrawY == YLast) ? 10'd0 : DrawY + 10'd1;
  assign yn_rel      = y_next - PlayY0;
  assign y_phase     = 4'(DrawY - PlayY0);
  assign col         = 5'(DrawX >> 4);
  assign yn_in_field = (y_next >= PlayY0) && (y_next < PlayEnd);
  assign y_in_field  = (DrawY >= PlayY0) && (DrawY < PlayEnd);
  // Fetch for the coming tile row starts at hblank of the line before it.
  assign trigger     = pix_en && (DrawX == HActive) && yn_in_field && (yn_rel[3:0] == 4'd0);
  assign line_start  = pix_en && (DrawX == 10'd0) && y_in_field && (y_phase == 4'd0);

  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    row_addr_d     = row_addr_q;
    fetch_err_d    = fetch_err_q;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          row_addr_d = 5'(yn_rel >> 4);
          state_d    = StReq;
        end
      end
      StReq: begin
        if (map.row_ack) begin
          shadow_d       = map.row_data;
          shadow_valid_d = 1'b1;
          state_d        = StDone;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    if (line_start) begin
      state_d = StIdle;
      if (state_q == StReq && map.row_ack) begin
        // Ack landing on the deadline cycle still counts as on time.
        active_d       = map.row_data;
        shadow_valid_d = 1'b0;
      end else if (state_q == StReq) begin
        active_d    = '0;
        fetch_err_d = 1'b1;
      end else if (shadow_valid_q) begin
        active_d       = shadow_q;
        shadow_valid_d = 1'b0;
      end
    end

    // Pixel lookup uses the post-swap row so x=0 of a new tile row is correct.
    is_dug_valid_d = pix_en;
    is_dug_d       = is_dug_q;
    if (pix_en) begin
      is_dug_d = y_in_field && (DrawX < XEnd) && active_d[col];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= StIdle;
      active_q       <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      row_addr_q     <= '0;
      fetch_err_q    <= 1'b0;
      is_dug_q       <= 1'b0;
      is_dug_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      row_addr_q     <= row_addr_d;
      fetch_err_q    <= fetch_err_d;
      is_dug_q       <= is_dug_d;
      is_dug_valid_q <= is_dug_valid_d;
    end
  end

  assign map.row_req  = (state_q == StReq);
  assign map.row_addr = row_addr_q;
  assign is_dug       = is_dug_q;
  assign is_dug_valid = is_dug_valid_q;
  assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_dug_row_reader.sv
// Scans sampled pixels of the VGA raster against an event-level model of tile-row rendering,
// with a map responder whose ack delay is chosen per row.
module tb_dug_row_reader;
  localparam int PY0   = 96;
  localparam int NROWS = 24;
  localparam int VT    = 525;
  localparam int HA    = 640;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       pix_en;
  logic [9:0] DrawX, DrawY;
  logic       is_dug, is_dug_valid, fetch_err;

  dug_row_reader_if bus ();

  dug_row_reader #(
    .PLAY_Y0 (PY0),
    .COLS    (32),
    .ROWS    (NROWS),
    .H_ACTIVE(HA),
    .V_TOTAL (VT)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_en      (pix_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .map         (bus),
    .is_dug      (is_dug),
    .is_dug_valid(is_dug_valid),
    .fetch_err   (fetch_err)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int cur_x, cur_y;

  logic [31:0] map_mem   [NROWS];
  int          delay_tab [NROWS];

  // Map responder state
  bit          rsp_busy, rsp_done;
  int          rsp_cnt;
  logic [4:0]  rsp_addr;

  // Reference model: pending request, fetched-but-not-shown row, row on screen
  bit          m_req, m_wait, m_err, m_dug, m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_fetched, cur_row;

  function automatic bit in_field(input int y);
    return (y >= PY0) && (y < PY0 + 16 * NROWS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s y=%0d x=%0d: observed %0h expected %0h", tag, cur_y, cur_x, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".row_req"}, {31'd0, bus.row_req}, 32'd0);
    chk({tag, ".row_addr"}, {27'd0, bus.row_addr}, 32'd0);
    chk({tag, ".is_dug"}, {31'd0, is_dug}, 32'd0);
    chk({tag, ".is_dug_valid"}, {31'd0, is_dug_valid}, 32'd0);
    chk({tag, ".fetch_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  task automatic model_reset();
    m_req = 0; m_wait = 0; m_err = 0; m_dug = 0; m_valid = 0;
    m_addr = '0; m_fetched = '0; cur_row = '0;
    rsp_busy = 0; rsp_done = 0; rsp_cnt = 0; rsp_addr = '0;
  endtask

  // One clock: drive at negedge, model the cycle, check at the following negedge.
  task automatic cyc(input bit pe, input int x, input int y, input bit fack);
    bit          ack, trig, ls;
    int          yn;
    logic [31:0] data;
    ack = 1'b0;
    if (bus.row_req) begin
      if (!rsp_busy) begin
        rsp_busy = 1; rsp_cnt = delay_tab[bus.row_addr]; rsp_addr = bus.row_addr;
      end
      if (!rsp_done) begin
        if (rsp_cnt == 0) begin ack = 1'b1; rsp_done = 1; end
        else rsp_cnt--;
      end
    end else begin
      rsp_busy = 0; rsp_done = 0;
    end
    if (fack) ack = 1'b1;
    data = ack ? (fack ? 32'hDEAD_BEEF : map_mem[rsp_addr]) : $urandom();
    cur_x = x; cur_y = y;
    pix_en = pe; DrawX = 10'(x); DrawY = 10'(y);
    bus.row_ack = ack; bus.row_data = data;

    yn   = (y == VT - 1) ? 0 : y + 1;
    trig = pe && (x == HA) && in_field(yn) && (((yn - PY0) % 16) == 0);
    ls   = pe && (x == 0) && in_field(y) && (((y - PY0) % 16) == 0);
    if (trig && !m_req && !m_wait) begin m_req = 1; m_addr = 5'((yn - PY0) / 16); end
    if (m_req && ack) begin m_req = 0; m_wait = 1; m_fetched = data; end
    if (ls) begin
      if (m_wait) begin cur_row = m_fetched; m_wait = 0; end
      else if (m_req) begin cur_row = '0; m_err = 1; m_req = 0; end
    end
    if (pe) m_dug = (in_field(y) && x < 512) ? cur_row[x / 16] : 1'b0;
    m_valid = pe;

    @(negedge Clk);
    chk("is_dug", {31'd0, is_dug}, {31'd0, m_dug});
    chk("is_dug_valid", {31'd0, is_dug_valid}, {31'd0, m_valid});
    chk("row_req", {31'd0, bus.row_req}, {31'd0, m_req});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    if (m_req) chk("row_addr", {27'd0, bus.row_addr}, {27'd0, m_addr});
  endtask

  // mode 0: pix_en always high; 1: alternating; 2: random idle gaps
  task automatic line(input int y, input int mode, input int nblank);
    int xs[$];
    xs.push_back(0); xs.push_back(15); xs.push_back(16);
    for (int t = 1; t < 32; t++) xs.push_back(16 * t + int'($urandom_range(15, 0)));
    xs.push_back(511); xs.push_back(512); xs.push_back(513);
    for (int b = 0; b < nblank; b++) xs.push_back(HA + b);
    foreach (xs[i]) begin
      int gaps;
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(2, 0)) : 0;
      for (int g = 0; g < gaps; g++) cyc(1'b0, xs[i], y, 1'b0);
      cyc(1'b1, xs[i], y, 1'b0);
    end
  endtask

  task automatic run_lines(input int lo, input int hi, input int mode);
    for (int y = lo; y <= hi; y++) line(y, mode, 8);
  endtask

  task automatic run_frame(input int mode);
    run_lines(0, 2, mode);
    run_lines(93, 482, mode);
    run_lines(522, 524, mode);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; pix_en = 1'b0; DrawX = '0; DrawY = '0;
    bus.row_ack = 1'b0; bus.row_data = '0;
    model_reset();
    #1 chk_reset("por");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Every row acked after 3 cycles with only tile 0 dug
    for (int r = 0; r < NROWS; r++) begin map_mem[r] = 32'h0000_0001; delay_tab[r] = 3; end
    run_frame(0);

    // Row 0 rightmost tile, row 3 acked on the line-start cycle, row 5 never acked
    for (int r = 0; r < NROWS; r++) begin map_mem[r] = $urandom(); delay_tab[r] = 3; end
    map_mem[0] = 32'h8000_0000;
    map_mem[3] = 32'hFFFF_FFFF; delay_tab[3] = 7;
    delay_tab[5] = 1000;
    run_frame(0);
    chk("fetch_err_sticky", {31'd0, fetch_err}, 32'd1);

    // Async reset while a request is outstanding, then a stray ack
    map_mem[0] = 32'hFFFF_FFFF; delay_tab[0] = 3; delay_tab[1] = 1000;
    run_lines(94, 110, 0);
    line(111, 0, 2);
    cyc(1'b1, 5, 111, 1'b0);
    pix_en = 1'b0; bus.row_ack = 1'b0;
    #2 Reset_n = 1'b0;
    #1 chk_reset("async_rst");
    model_reset();
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) cyc(1'b1, 645, 111, 1'b1);
    run_lines(112, 140, 0);

    // Alternating pix_en with random rows and short delays
    for (int r = 0; r < NROWS; r++) begin
      map_mem[r] = $urandom(); delay_tab[r] = int'($urandom_range(6, 0));
    end
    run_lines(94, 174, 1);

    // Random pix_en gaps with delays that sometimes miss the deadline
    for (int r = 0; r < NROWS; r++) begin
      map_mem[r] = $urandom(); delay_tab[r] = int'($urandom_range(24, 0));
    end
    run_lines(94, 175, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
